gate_controller: RTL and testbench
==================================

// Module: gate_controller
// PURPOSE
//  Parking-gate controller; consumes the vehicle-sensor and keypad stimulus (Vehiculo, Termino, Pin, enterPin).
//  Checks the entered PIN, opens the gate, counts wrong attempts, raises Alarma and locks on tailgating.
//  Sits between keypad/sensors and the gate actuator; all outputs registered (Moore).
// PARAMETERS
//  PIN_CORRECTO  8'h10  accepted 8-bit PIN
//  MAX_INTENTOS  3      wrong attempts that raise Alarma (>=1)
//  CNT_W         2      attempt-counter width; must hold MAX_INTENTOS
// PORTS
//  Clk       in   1  system clock, rising edge
//  Reset     in   1  asynchronous, active-low reset
//  Vehiculo  in   1  vehicle present at gate
//  Termino   in   1  one-cycle pulse: vehicle finished passing
//  enterPin  in   1  keypad enter key
//  Pin       in   8  keypad PIN value, sampled on enter event
//  Cerrado   out  1  gate closed
//  Abierto   out  1  gate open
//  Alarma    out  1  alarm lamp
//  Bloqueo   out  1  gate locked (tailgating)
// BEHAVIOUR
//  Reset low: state=CERRADO, intentos=0; Cerrado=1, Abierto=0, Alarma=0, Bloqueo=0.
//  Enter event ("ev"): see CONFIGURATION. Pin compared only on the edge where ev=1.
//  Transitions commit at rising Clk; outputs show the new state after that same edge (1-cycle latency).
//  CERRADO  (Cerrado=1): Vehiculo=1 -> ESPERA_PIN. ev/Termino ignored.
//  ESPERA_PIN (Cerrado=1):
//   - ev & Pin==PIN_CORRECTO -> ABIERTO; intentos<=0; Alarma<=0.
//   - ev & wrong Pin -> stay; intentos saturating +1; Alarma<=1 once intentos+1>=MAX_INTENTOS.
//   - Vehiculo=0 (no ev) -> CERRADO; intentos and Alarma kept.
//   - ev and Vehiculo=0 same cycle: PIN evaluation wins.
//  ABIERTO (Abierto=1):
//   - Termino & Vehiculo -> BLOQUEO (tailgating).
//   - Termino & !Vehiculo -> CERRADO.
//   - ev ignored.
//  BLOQUEO (Bloqueo=1, Alarma=1, Cerrado=0, Abierto=0):
//   - ev & correct Pin -> ABIERTO; Alarma<=0; intentos<=0.
//   - wrong Pin: stay; counter saturates. Only other exit: Reset.
//  Alarma outside BLOQUEO = attempt flag above; exactly one of Cerrado/Abierto/Bloqueo high.
//  Counter never wraps (saturates at 2**CNT_W-1). Reset mid-operation: immediate return to reset values.
// CONFIGURATION
//  ENTER_EDGE_EN defined: ev = enterPin & ~enterPin_q (registered, reset 0);
//   one evaluation per press however long held.
//  Not defined: ev = enterPin level; each cycle enterPin is high counts as one entry.
//  One-cycle presses behave identically in both builds.
// STRUCTURE
//  Package gate_pkg: state encoding (CERRADO, ESPERA_PIN, ABIERTO, BLOQUEO; 2-bit), default PIN and MAX_INTENTOS.
//  Sub-module pin_checker: ev generation, PIN compare, saturating attempt counter.
//   Outputs pin_ok, pin_bad, alarm_cnt; clear input from top FSM.
//  Top: state register, next-state logic, registered output decode.
// TESTING  (Clk period 10, PIN_CORRECTO=8'h10, MAX_INTENTOS=3)
//  1 Reset low mid-ABIERTO -> next sample Cerrado=1, others 0, intentos=0.
//  2 Vehiculo=1, ev Pin=8'h10 -> Abierto=1 next edge; Termino pulse with Vehiculo=0 -> Cerrado=1.
//  3 Four ev with Pin=8'hFF -> Alarma=1 after 3rd, still Cerrado; ev Pin=8'h10 -> Abierto=1, Alarma=0.
//  4 In ABIERTO, Termino=1 & Vehiculo=1 -> Bloqueo=1, Alarma=1; ev 8'hFF stays; ev 8'h10 -> Abierto=1.
//  5 Hold enterPin 3 cycles, Pin=8'h00: ENTER_EDGE_EN -> intentos=1; undefined -> intentos=3, Alarma=1.
//  6 ESPERA_PIN, ev Pin=8'h10 same cycle Vehiculo falls -> Abierto=1 (PIN wins).

Source files
------------

// File: rtl/gate_pkg.sv
// Shared definitions for the parking-gate controller: state encoding and
// default configuration values.
package gate_pkg;

  typedef logic [1:0] state_t;

  localparam state_t CERRADO    = 2'd0;
  localparam state_t ESPERA_PIN = 2'd1;
  localparam state_t ABIERTO    = 2'd2;
  localparam state_t BLOQUEO    = 2'd3;

  localparam logic [7:0] PIN_DEFAULT          = 8'h10;
  localparam int         MAX_INTENTOS_DEFAULT = 3;

endpackage

// File: rtl/pin_checker.sv
// PIN evaluation for the gate controller: builds the enter event, compares
// the keypad value and keeps a saturating wrong-attempt counter.
// Build option: ENTER_EDGE_EN makes the enter event a rising-edge detect on
// enterPin (one evaluation per press); otherwise every high cycle counts.
import gate_pkg::*;

module pin_checker #(
  parameter logic [7:0] PIN_CORRECTO = PIN_DEFAULT,
  parameter int         MAX_INTENTOS = MAX_INTENTOS_DEFAULT,
  parameter int         CNT_W        = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic       i_enter,
  input  logic [7:0] i_pin,
  output logic       o_pin_ok,
  output logic       o_pin_bad,
  output logic       o_alarm_cnt
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INTENTOS);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ev;

`ifdef ENTER_EDGE_EN
  logic r_enter_q;

  // Delayed copy of the enter key for rising-edge detection
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_enter_q <= 1'b0;
    else        r_enter_q <= i_enter;
  end

  assign w_ev = i_enter & ~r_enter_q;
`else
  assign w_ev = i_enter;
`endif

  assign o_pin_ok  = i_en & w_ev & (i_pin == PIN_CORRECTO);
  assign o_pin_bad = i_en & w_ev & (i_pin != PIN_CORRECTO);

  // Next attempt count: clear on accepted PIN, saturating increment on a wrong one
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clr)          w_cnt_next = '0;
    else if (o_pin_bad) w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + ONE_C;
  end

  // Alarm flag seen by the FSM after this edge tracks the count that will be stored
  assign o_alarm_cnt = (w_cnt_next >= MAX_C);

  // Attempt counter register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_cnt <= '0;
    else        r_cnt <= w_cnt_next;
  end

endmodule

// File: rtl/gate_controller.sv
// Parking-gate controller: PIN-gated entry, wrong-attempt alarm and lock on
// tailgating. All outputs are registered decodes of the next state.
// Build option: ENTER_EDGE_EN (see pin_checker) selects edge-detected entry.
import gate_pkg::*;

module gate_controller #(
  parameter logic [7:0] PIN_CORRECTO = PIN_DEFAULT,
  parameter int         MAX_INTENTOS = MAX_INTENTOS_DEFAULT,
  parameter int         CNT_W        = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Vehiculo,
  input  logic       Termino,
  input  logic       enterPin,
  input  logic [7:0] Pin,
  output logic       Cerrado,
  output logic       Abierto,
  output logic       Alarma,
  output logic       Bloqueo
);

  state_t r_state;
  state_t w_next;
  logic   w_en;
  logic   w_pin_ok;
  logic   w_pin_bad;
  logic   w_alarm_cnt;

  // PIN is only evaluated while waiting for it or while locked
  assign w_en = (r_state == ESPERA_PIN) || (r_state == BLOQUEO);

  pin_checker #(
    .PIN_CORRECTO (PIN_CORRECTO),
    .MAX_INTENTOS (MAX_INTENTOS),
    .CNT_W        (CNT_W)
  ) u_pin_checker (
    .Clk         (Clk),
    .Reset       (Reset),
    .i_en        (w_en),
    .i_clr       (w_pin_ok),
    .i_enter     (enterPin),
    .i_pin       (Pin),
    .o_pin_ok    (w_pin_ok),
    .o_pin_bad   (w_pin_bad),
    .o_alarm_cnt (w_alarm_cnt)
  );

  // Next-state logic; a PIN evaluation takes priority over the vehicle leaving
  always_comb begin
    w_next = r_state;
    case (r_state)
      CERRADO: begin
        if (Vehiculo) w_next = ESPERA_PIN;
      end
      ESPERA_PIN: begin
        if (w_pin_ok)       w_next = ABIERTO;
        else if (w_pin_bad) w_next = ESPERA_PIN;
        else if (!Vehiculo) w_next = CERRADO;
      end
      ABIERTO: begin
        if (Termino) w_next = Vehiculo ? BLOQUEO : CERRADO;
      end
      BLOQUEO: begin
        if (w_pin_ok) w_next = ABIERTO;
      end
      default: w_next = CERRADO;
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= CERRADO;
    else        r_state <= w_next;
  end

  // Registered Moore outputs decoded from the state being entered
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Cerrado <= 1'b1;
      Abierto <= 1'b0;
      Alarma  <= 1'b0;
      Bloqueo <= 1'b0;
    end else begin
      Cerrado <= (w_next == CERRADO) || (w_next == ESPERA_PIN);
      Abierto <= (w_next == ABIERTO);
      Alarma  <= (w_next == BLOQUEO) || w_alarm_cnt;
      Bloqueo <= (w_next == BLOQUEO);
    end
  end

endmodule

// File: tb/tb_gate_controller.sv
// Self-checking bench for gate_controller: a behavioural model of the gate
// rules checked every cycle, plus hand-computed literal expectations.
module tb_gate_controller;

  localparam logic [7:0] PIN_OK = 8'h10;
  localparam int         MAXI   = 3;
  localparam int         SAT    = 3;

  logic       Clk      = 1'b0;
  logic       Reset    = 1'b1;
  logic       Vehiculo = 1'b0;
  logic       Termino  = 1'b0;
  logic       enterPin = 1'b0;
  logic [7:0] Pin      = 8'h00;
  logic       Cerrado, Abierto, Alarma, Bloqueo;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // model: mode 0=closed, 1=waiting for PIN, 2=open, 3=locked
  int m_mode  = 0;
  int m_tries = 0;
  bit m_alarm = 1'b0;
  bit m_prev  = 1'b0;

  gate_controller #(.PIN_CORRECTO(PIN_OK), .MAX_INTENTOS(MAXI), .CNT_W(2)) dut (
    .Clk(Clk), .Reset(Reset), .Vehiculo(Vehiculo), .Termino(Termino),
    .enterPin(enterPin), .Pin(Pin),
    .Cerrado(Cerrado), .Abierto(Abierto), .Alarma(Alarma), .Bloqueo(Bloqueo)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model of the gate rules
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_mode = 0; m_tries = 0; m_alarm = 0; m_prev = 0;
    end else begin
      bit ev;
`ifdef ENTER_EDGE_EN
      ev = enterPin && !m_prev;
`else
      ev = enterPin;
`endif
      if (m_mode == 0) begin
        if (Vehiculo) m_mode = 1;
      end else if (m_mode == 1) begin
        if (ev && Pin == PIN_OK) begin
          m_mode = 2; m_tries = 0; m_alarm = 0;
        end else if (ev) begin
          if (m_tries < SAT) m_tries = m_tries + 1;
          if (m_tries >= MAXI) m_alarm = 1;
        end else if (!Vehiculo) m_mode = 0;
      end else if (m_mode == 2) begin
        if (Termino) m_mode = Vehiculo ? 3 : 0;
      end else begin
        if (ev && Pin == PIN_OK) begin
          m_mode = 2; m_tries = 0; m_alarm = 0;
        end else if (ev && m_tries < SAT) m_tries = m_tries + 1;
      end
      m_prev = enterPin;
    end
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge Clk) begin
    if (chk_on) begin
      check("model_Cerrado", Cerrado, (m_mode <= 1));
      check("model_Abierto", Abierto, (m_mode == 2));
      check("model_Bloqueo", Bloqueo, (m_mode == 3));
      check("model_Alarma",  Alarma,  (m_mode == 3) || m_alarm);
    end
  end

  task automatic cyc(input logic v, input logic t, input logic e, input logic [7:0] p);
    Vehiculo = v; Termino = t; enterPin = e; Pin = p;
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic v, input logic [7:0] p);
    cyc(v, 1'b0, 1'b1, p);
    cyc(v, 1'b0, 1'b0, p);
  endtask

  task automatic pulse_reset(input string tag);
    #2 Reset = 1'b0;
    #1;
    check({tag, "_Cerrado"}, Cerrado, 1'b1);
    check({tag, "_Abierto"}, Abierto, 1'b0);
    check({tag, "_Alarma"},  Alarma,  1'b0);
    check({tag, "_Bloqueo"}, Bloqueo, 1'b0);
    #2 Reset = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 Reset = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("rst_Cerrado", Cerrado, 1'b1);
    check("rst_Abierto", Abierto, 1'b0);
    check("rst_Alarma",  Alarma,  1'b0);
    check("rst_Bloqueo", Bloqueo, 1'b0);

    // correct PIN opens, vehicle passing alone closes
    cyc(1, 0, 0, 8'h00);
    check("wait_Cerrado", Cerrado, 1'b1);
    press(1, PIN_OK);
    check("open_Abierto", Abierto, 1'b1);
    check("open_Cerrado", Cerrado, 1'b0);
    cyc(0, 1, 0, 8'h00);
    check("pass_Cerrado", Cerrado, 1'b1);

    // wrong attempts raise the alarm on the third, correct PIN clears it
    cyc(1, 0, 0, 8'h00);
    press(1, 8'hFF);
    press(1, 8'hFF);
    check("two_bad_Alarma", Alarma, 1'b0);
    press(1, 8'hFF);
    check("three_bad_Alarma", Alarma, 1'b1);
    check("three_bad_Cerrado", Cerrado, 1'b1);
    press(1, 8'hFF);
    check("four_bad_Alarma", Alarma, 1'b1);
    press(1, PIN_OK);
    check("recover_Abierto", Abierto, 1'b1);
    check("recover_Alarma", Alarma, 1'b0);

    // tailgating locks, only the correct PIN unlocks
    cyc(1, 1, 0, 8'h00);
    check("tail_Bloqueo", Bloqueo, 1'b1);
    check("tail_Alarma", Alarma, 1'b1);
    check("tail_Cerrado", Cerrado, 1'b0);
    check("tail_Abierto", Abierto, 1'b0);
    press(1, 8'hFF);
    check("lock_bad_Bloqueo", Bloqueo, 1'b1);
    press(1, PIN_OK);
    check("unlock_Abierto", Abierto, 1'b1);
    check("unlock_Bloqueo", Bloqueo, 1'b0);
    check("unlock_Alarma", Alarma, 1'b0);

    // alarm survives the vehicle leaving the keypad
    cyc(0, 1, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    press(1, 8'hFF);
    press(1, 8'hFF);
    press(1, 8'hFF);
    cyc(0, 0, 0, 8'h00);
    check("leave_Cerrado", Cerrado, 1'b1);
    check("leave_Alarma", Alarma, 1'b1);

    // reset in the middle of ABIERTO
    cyc(1, 0, 0, 8'h00);
    press(1, PIN_OK);
    check("pre_rst_Abierto", Abierto, 1'b1);
    pulse_reset("rst_open");

    // reset clears the attempt counter
    cyc(1, 0, 0, 8'h00);
    press(1, 8'hFF);
    press(1, 8'hFF);
    pulse_reset("rst_cnt");
    cyc(1, 0, 0, 8'h00);
    press(1, 8'hFF);
    check("cnt_cleared_Alarma", Alarma, 1'b0);
    press(1, PIN_OK);
    cyc(0, 1, 0, 8'h00);

    // enterPin held for three cycles with a wrong PIN
    cyc(1, 0, 0, 8'h00);
    cyc(1, 0, 1, 8'h00);
    cyc(1, 0, 1, 8'h00);
    cyc(1, 0, 1, 8'h00);
    cyc(1, 0, 0, 8'h00);
`ifdef ENTER_EDGE_EN
    check("hold_Alarma", Alarma, 1'b0);
`else
    check("hold_Alarma", Alarma, 1'b1);
`endif
    check("hold_Cerrado", Cerrado, 1'b1);
    press(1, PIN_OK);
    check("hold_exit_Abierto", Abierto, 1'b1);

    // PIN evaluation wins over the vehicle leaving in the same cycle
    cyc(0, 1, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, PIN_OK);
    check("pin_wins_Abierto", Abierto, 1'b1);
    cyc(0, 0, 0, 8'h00);
    press(0, 8'hFF);
    check("open_ignores_ev", Abierto, 1'b1);

    // closed gate ignores Termino and the keypad
    cyc(0, 1, 0, 8'h00);
    cyc(0, 1, 1, PIN_OK);
    check("closed_ignores", Cerrado, 1'b1);
    cyc(0, 0, 0, 8'h00);

    @(negedge Clk);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
